// File: rtl/data_memory.sv
// data_memory: byte-addressed little-endian RV32 data memory behind valid/ready
// request and response channels, one access in flight at a time.
module data_memory #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);
  localparam int AW = $clog2(DEPTH_BYTES);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_d;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [7:0]  mem [DEPTH_BYTES];
  logic [AW-1:0] a0, a1, a2, a3;
  logic        bad_f3, misaligned, err;
  logic [31:0] word, load_data;
  always_comb begin
    a0 = addr_q[AW-1:0];
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    a3 = a0 + AW'(3);
    bad_f3 = we_q ? (f3_q > 3'd2) : (f3_q == 3'd3 || f3_q[2:1] == 2'b11);
    misaligned = (f3_q[1:0] == 2'd1 && addr_q[0]) || (f3_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0);
    err = bad_f3 || misaligned || addr_q >= 32'(DEPTH_BYTES);
    word = {mem[a3], mem[a2], mem[a1], mem[a0]};
    // funct3[2] selects the unsigned (zero-extending) load variants
    load_data = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & word[7]}}, word[7:0]} :
                f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & word[15]}}, word[15:0]} : word;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state == IDLE   ? (req_valid ? ACCESS : IDLE) :
              state == ACCESS ? RESP : (resp_ready ? IDLE : RESP);
    req_ready = state == IDLE;
    resp_valid = state == RESP;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      we_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        resp_error <= err;
        resp_rdata <= (err || we_q) ? '0 : load_data;
      end
    end
  // Array is deliberately unreset; a reset before the ACCESS edge leaves state IDLE, dropping the store
  always_ff @(posedge clk)
    if (state == ACCESS && we_q && !err) begin
      mem[a0] <= wdata_q[7:0];
      if (f3_q[1:0] != 2'd0) mem[a1] <= wdata_q[15:8];
      if (f3_q[1]) begin
        mem[a2] <= wdata_q[23:16];
        mem[a3] <= wdata_q[31:24];
      end
    end
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and randomized checks of data_memory against a byte-array reference model.
module tb_data_memory;
  localparam int DEPTH = 1024;
  logic clk = 1'b0, resetn = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [2:0] req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;
  byte unsigned ref_mem [DEPTH];
  int vectors = 0, miscompares = 0;

  data_memory #(.DEPTH_BYTES(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_size(bit we, bit [2:0] f3);
    if (we) return f3 == 0 ? 1 : f3 == 1 ? 2 : f3 == 2 ? 4 : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_err(bit we, bit [2:0] f3, bit [31:0] addr);
    int s = op_size(we, f3);
    if (s == 0) return 1'b1;
    if (addr >= DEPTH) return 1'b1;
    return (addr % s) != 0;
  endfunction

  function automatic bit [31:0] ref_load(bit [2:0] f3, bit [31:0] addr);
    int s = op_size(1'b0, f3);
    longint v = 0;
    for (int i = 0; i < s; i++) v += longint'(ref_mem[addr + i]) << (8 * i);
    if (f3 < 4 && s < 4 && v >= (longint'(1) << (8 * s - 1))) v -= longint'(1) << (8 * s);
    return v[31:0];
  endfunction

  function automatic void ref_store(bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata);
    int s = op_size(1'b1, f3);
    for (int i = 0; i < s; i++) ref_mem[addr + i] = byte'(wdata >> (8 * i));
  endfunction

  task automatic issue(bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata, string tag);
    bit e = ref_err(we, f3, addr);
    bit [31:0] d = (e || we) ? 32'h0 : ref_load(f3, addr);
    @(negedge clk);
    check({tag, " idle ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " access no resp"}, {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
    check({tag, " rdata"}, resp_rdata, d);
    check({tag, " error"}, {31'b0, resp_error}, {31'b0, e});
    @(negedge clk);
    check({tag, " consumed"}, {30'b0, resp_valid, req_ready}, 32'd1);
    if (we && !e) ref_store(f3, addr, wdata);
  endtask

  initial begin
    bit [31:0] held;
    #1;
    check("reset outputs", {resp_rdata[29:0], resp_error, resp_valid}, 32'd0);
    check("reset ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    for (int a = 0; a < DEPTH; a += 4) issue(1'b1, 3'd2, a, $urandom, "fill");

    issue(1'b1, 3'd2, 32'h10, 32'h8000_00FF, "sw 0x10");
    issue(1'b0, 3'd2, 32'h10, 0, "lw 0x10");
    issue(1'b0, 3'd0, 32'h10, 0, "lb 0x10");
    issue(1'b0, 3'd4, 32'h10, 0, "lbu 0x10");
    issue(1'b0, 3'd1, 32'h12, 0, "lh 0x12");
    issue(1'b0, 3'd5, 32'h12, 0, "lhu 0x12");
    check("model lh 0x12", ref_load(3'd1, 32'h12), 32'hFFFF_8000);
    issue(1'b1, 3'd0, 32'h11, 32'h1234_56AB, "sb 0x11");
    issue(1'b0, 3'd2, 32'h10, 0, "lw after sb");
    check("model sb merge", ref_load(3'd2, 32'h10), 32'h8000_ABFF);
    issue(1'b1, 3'd1, 32'h21, 32'hFFFF_FFFF, "sh misaligned");
    issue(1'b0, 3'd2, 32'h20, 0, "lw after bad sh");
    issue(1'b0, 3'd2, 32'h22, 0, "lw misaligned");
    issue(1'b1, 3'd2, 32'h400, 32'h1111_2222, "sw out of range");
    issue(1'b0, 3'd3, 32'h10, 0, "load f3=3");
    issue(1'b1, 3'd5, 32'h10, 32'hFFFF_FFFF, "store f3=5");
    issue(1'b0, 3'd2, 32'h10, 0, "lw after bad stores");
    issue(1'b1, 3'd0, DEPTH - 1, 32'h0000_00C3, "sb top byte");
    issue(1'b0, 3'd4, DEPTH - 1, 0, "lbu top byte");
    issue(1'b1, 3'd2, DEPTH - 4, 32'hCAFE_F00D, "sw top word");
    issue(1'b0, 3'd2, DEPTH - 4, 0, "lw top word");
    issue(1'b0, 3'd4, DEPTH, 0, "lbu past end");

    // stalled response with a new request waiting
    held = ref_load(3'd2, 32'h10);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; resp_ready = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h40; req_wdata = 32'h0000_005A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall resp_valid", {31'b0, resp_valid}, 32'd1);
      check("stall rdata", resp_rdata, held);
      check("stall req_ready", {31'b0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("stall released", {30'b0, resp_valid, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("queued accepted", {30'b0, resp_valid, req_ready}, 32'd0);
    @(negedge clk);
    check("queued resp", {resp_rdata[29:0], resp_error, resp_valid}, 32'd1);
    ref_store(3'd0, 32'h40, 32'h0000_005A);
    issue(1'b0, 3'd4, 32'h40, 0, "lbu queued store");

    // reset during ACCESS drops the store
    issue(1'b1, 3'd2, 32'h30, 32'h0, "sw zero 0x30");
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    #1 resetn = 1'b0;
    #1;
    check("async reset", {30'b0, resp_valid, req_ready}, 32'd1);
    check("async reset rdata", {resp_rdata[30:0], resp_error}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    issue(1'b0, 3'd2, 32'h30, 0, "lw after dropped sw");

    for (int n = 0; n < 300; n++) begin
      bit [31:0] a;
      int k = $urandom_range(0, 9);
      a = k == 0 ? DEPTH + $urandom_range(0, 7) : k == 1 ? DEPTH - 1 - $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
      issue($urandom_range(0, 1), 3'($urandom_range(0, 7)), a, $urandom, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressed, little-endian RV32 data memory serving the multicycle core's load/store path. It is the read/write counterpart of the read-only instruction memory: it accepts one request at a time on a valid/ready request channel, decodes the RV32I load/store width from `funct3`, commits byte-lane writes, and returns sign- or zero-extended load data on a valid/ready response channel. Misaligned, out-of-range and illegal-width accesses are reported as errors and never modify memory.

## Interface
- `DEPTH_BYTES`, 1024, memory size in bytes; a multiple of 4; addresses `0 .. DEPTH_BYTES-1` are valid.
- `clk` in 1: single clock; all state updates on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low bits of the word.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out 32: load result after extension; 0 for stores and errors.
- `resp_error` out 1: access faulted.

## Operation
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: `req_ready`=1. When `req_valid` is high, the block latches `req_we`, `req_funct3`, `req_addr` and `req_wdata`, then moves to ACCESS.
  - ACCESS: the block checks the latched request, performs the write or read, registers `resp_rdata`/`resp_error`, then moves to RESP.
  - RESP: `resp_valid`=1, and the outputs stay stable until `resp_valid && resp_ready`. The block then returns to IDLE.
- Request fields are ignored outside IDLE. `req_ready` is 0 in ACCESS and RESP.
- Error conditions (any one sets the error):
  - halfword access with `addr[0]` != 0;
  - word access with `addr[1:0]` != 0;
  - `addr >= DEPTH_BYTES`;
  - illegal funct3: load 3, 6 or 7; store 3 through 7.
- On error: no byte is written, `resp_rdata`=0, `resp_error`=1.
- Byte ordering is little-endian. A word at address A is `{mem[A+3], mem[A+2], mem[A+1], mem[A]}`.
- Stores write exactly 1, 2 or 4 bytes: SB takes `wdata[7:0]`, SH takes `wdata[15:0]`, SW takes `wdata[31:0]`. Other bytes are unchanged.
- Load extension:
  - LB and LH sign-extend from bit 7 and bit 15;
  - LBU and LHU zero-extend;
  - LW passes the word through.
- A store returns `resp_rdata`=0, `resp_error`=0.
- The memory array is not cleared by reset; its contents after power-up are undefined. Reset does not alter previously written bytes.

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0.
- Request accepted at edge N: ACCESS during cycle N..N+1.
- Memory write commits at edge N+1; `resp_valid` rises after edge N+1.
- Minimum acceptance-to-response latency: 2 cycles.
- Response consumed at edge M (`resp_valid && resp_ready`): IDLE after M, so `req_ready`=1 in cycle M+1. Maximum throughput is one access per 3 cycles.
- `resp_ready` held high in advance: the response is consumed on the first RESP cycle.
- `resp_ready` low: hold indefinitely, with no change to outputs.
- Reset mid-operation: `resetn` low forces IDLE immediately and clears the response outputs.
  - Reset asserted before edge N+1: the pending store is dropped and memory is unchanged.
  - Reset asserted after edge N+1: the store remains committed.
- Highest-byte access: an SB or LBU to `DEPTH_BYTES-1` is legal. An SW to `DEPTH_BYTES-4` is legal. An access to `DEPTH_BYTES` faults.

## Test plan
- SW `0x8000_00FF` to addr 0x10, then LW 0x10 → `resp_rdata`=0x8000_00FF, `resp_error`=0, `resp_valid` two cycles after acceptance.
- After that store, LB 0x10 → 0xFFFF_FFFF; LBU 0x10 → 0x0000_00FF; LH 0x12 → 0xFFFF_8000; LHU 0x12 → 0x0000_8000.
- SB `0x1234_56AB` to 0x11 over word 0x8000_00FF at 0x10, then LW 0x10 → 0x8000_ABFF; only byte 0x11 changed.
- Error cases, each → `resp_error`=1, `resp_rdata`=0, memory unchanged (confirmed by a later LW):
  - SH to 0x21;
  - LW to 0x22;
  - SW to 0x400 with default depth;
  - load with funct3=3.
- Hold `resp_ready`=0 for 5 cycles with `req_valid` high and new request fields → `resp_valid`=1 with stable data, `req_ready`=0, new request not accepted. Raise `resp_ready` → the new request is accepted on the cycle after consumption.
- Accept SW 0xDEAD_BEEF to 0x30 over known contents 0, then pull `resetn` low during ACCESS before the commit edge → `resp_valid`=0 and `req_ready`=1 asynchronously; a subsequent LW 0x30 → 0.
